// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generator, single-outstanding memory handshake and DEPTH-entry instruction queue.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue_unit #(
    parameter int                 WIDTH    = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         RedirectValid,
    input  logic [WIDTH-1:0]             RedirectPC,
    output logic                         IReqValid,
    output logic [WIDTH-1:0]             IReqAddr,
    input  logic                         IReqReady,
    input  logic                         IRespValid,
    input  logic [WIDTH-1:0]             IRespData,
    output logic                         InstrValidD,
    output logic [WIDTH-1:0]             InstrD,
    output logic [WIDTH-1:0]             PCPlus4D,
    input  logic                         DecodeStall,
    output logic [$clog2(DEPTH+1)-1:0]   QueueCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetchState_t;

    fetchState_t      stateReg, stateNext;
    logic [WIDTH-1:0] fetchPcReg, fetchPcNext;
    logic [PW-1:0]    headPtrReg, headPtrNext;
    logic [PW-1:0]    tailPtrReg, tailPtrNext;
    logic [CW-1:0]    countReg, countNext;

    logic [WIDTH-1:0] slotInstr   [DEPTH];
    logic [WIDTH-1:0] slotPcPlus4 [DEPTH];

    logic queueEmpty, queueFull;
    logic reqFire, respAccept, bypassActive, pushEn, popEn;

    assign queueEmpty = (countReg == '0);
    assign queueFull  = (countReg == CW'(DEPTH));

    assign IReqValid  = Reset & (stateReg == ISSUE) & ~queueFull & ~RedirectValid;
    assign IReqAddr   = fetchPcReg;
    assign QueueCount = Reset ? countReg : '0;

    assign reqFire    = IReqValid & IReqReady;
    assign respAccept = (stateReg == WAIT) & IRespValid & ~RedirectValid;

`ifdef FETCH_BYPASS_EN
    assign bypassActive = respAccept & queueEmpty;
`else
    assign bypassActive = 1'b0;
`endif

    // A bypassed response that decode consumes at once never enters the queue.
    assign pushEn = respAccept & ~(bypassActive & ~DecodeStall);
    assign popEn  = ~queueEmpty & ~DecodeStall & ~RedirectValid;

    // The PC already advanced on acceptance, so it equals the entry's PC+4 while waiting.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gSlot
            logic [WIDTH-1:0] instrReg;
            logic [WIDTH-1:0] pcPlus4Reg;

            always_ff @(posedge CLK) begin
                if (pushEn && (tailPtrReg == PW'(gi))) begin
                    instrReg   <= IRespData;
                    pcPlus4Reg <= fetchPcReg;
                end
            end

            assign slotInstr[gi]   = instrReg;
            assign slotPcPlus4[gi] = pcPlus4Reg;
        end
    endgenerate

    always_comb begin
        InstrValidD = 1'b0;
        InstrD      = '0;
        PCPlus4D    = '0;
        if (Reset) begin
            if (!queueEmpty) begin
                InstrValidD = 1'b1;
                InstrD      = slotInstr[headPtrReg];
                PCPlus4D    = slotPcPlus4[headPtrReg];
            end else if (bypassActive) begin
                InstrValidD = 1'b1;
                InstrD      = IRespData;
                PCPlus4D    = fetchPcReg;
            end
        end
    end

    always_comb begin
        stateNext   = stateReg;
        fetchPcNext = fetchPcReg;
        unique case (stateReg)
            ISSUE: if (reqFire) stateNext = WAIT;
            WAIT: begin
                if (IRespValid)         stateNext = ISSUE;
                else if (RedirectValid) stateNext = DROP;
            end
            DROP:    if (IRespValid) stateNext = ISSUE;
            default: stateNext = ISSUE;
        endcase
        if (RedirectValid)
            fetchPcNext = RedirectPC;
        else if (reqFire)
            fetchPcNext = fetchPcReg + WIDTH'(4);
    end

    always_comb begin
        headPtrNext = headPtrReg;
        tailPtrNext = tailPtrReg;
        countNext   = countReg;
        if (RedirectValid) begin
            headPtrNext = '0;
            tailPtrNext = '0;
            countNext   = '0;
        end else begin
            if (popEn)  headPtrNext = headPtrReg + PW'(1);
            if (pushEn) tailPtrNext = tailPtrReg + PW'(1);
            unique case ({pushEn, popEn})
                2'b10:   countNext = countReg + CW'(1);
                2'b01:   countNext = countReg - CW'(1);
                default: countNext = countReg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            stateReg   <= ISSUE;
            fetchPcReg <= RESET_PC;
            headPtrReg <= '0;
            tailPtrReg <= '0;
            countReg   <= '0;
        end else begin
            stateReg   <= stateNext;
            fetchPcReg <= fetchPcNext;
            headPtrReg <= headPtrNext;
            tailPtrReg <= tailPtrNext;
            countReg   <= countNext;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam bit NBY = !BYP;

    logic        CLK = 1'b0;
    logic        Reset, RedirectValid, IReqReady, IRespValid, DecodeStall;
    logic        IReqValid, InstrValidD;
    logic [31:0] RedirectPC, IReqAddr, IRespData, InstrD, PCPlus4D;
    logic [2:0]  QueueCount;

    fetch_queue_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .Reset(Reset), .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
        .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(IReqReady),
        .IRespValid(IRespValid), .IRespData(IRespData), .InstrValidD(InstrValidD),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D), .DecodeStall(DecodeStall), .QueueCount(QueueCount)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Memory model: one request at a time, response memLatency cycles after acceptance.
    bit          memPend = 0;
    logic [31:0] memAddr = '0;
    int          memCnt = 0;
    int          memLatency = 1;
    bit          readyEn = 1;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        resp;
        logic [31:0] data;
        logic        stall;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc4;
        int          eCount;
    } vec_t;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] sel(input bit c, input logic [31:0] v);
        return c ? v : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic memDrive();
        IReqReady  = readyEn;
        IRespValid = memPend && (memCnt == 0);
        IRespData  = (memPend && memCnt == 0) ? memWord(memAddr) : 32'h0;
    endtask

    task automatic stepNeg();
        memDrive();
        @(negedge CLK);
    endtask

    // Called between the negedge checks and the next rising edge.
    task automatic memEdge();
        bit          fire;
        bit          taken;
        logic [31:0] a;
        fire  = IReqValid && IReqReady;
        taken = IRespValid;
        a     = IReqAddr;
        @(posedge CLK);
        #1;
        if (taken && memPend) memPend = 0;
        else if (memPend && memCnt > 0) memCnt--;
        if (fire) begin
            memPend = 1;
            memAddr = a;
            memCnt  = memLatency - 1;
        end
    endtask

    vec_t vt [11];

    initial begin
        ent_t        mq [$];
        bit          mOut, mDoom;
        logic [31:0] mPc, mReqPc;
        bit          got, seen;
        logic [31:0] headI, headP;
        logic [31:0] fires [2];
        int          nf;

        vt[0]  = '{0, 0, 1, 0, 0,              0, 1, 32'h0,   0,   0,                         0,                 0};
        vt[1]  = '{0, 0, 1, 1, memWord(0),     0, 0, 32'h4,   BYP, sel(BYP, memWord(0)),      sel(BYP, 4),       0};
        vt[2]  = '{0, 0, 1, 0, 0,              0, 1, 32'h4,   NBY, sel(NBY, memWord(0)),      sel(NBY, 4),       int'(NBY)};
        vt[3]  = '{0, 0, 1, 1, memWord(4),     0, 0, 32'h8,   BYP, sel(BYP, memWord(4)),      sel(BYP, 8),       0};
        vt[4]  = '{0, 0, 1, 0, 0,              0, 1, 32'h8,   NBY, sel(NBY, memWord(4)),      sel(NBY, 8),       int'(NBY)};
        vt[5]  = '{0, 0, 1, 1, memWord(8),     0, 0, 32'hC,   BYP, sel(BYP, memWord(8)),      sel(BYP, 32'hC),   0};
        vt[6]  = '{0, 0, 0, 0, 0,              0, 1, 32'hC,   NBY, sel(NBY, memWord(8)),      sel(NBY, 32'hC),   int'(NBY)};
        vt[7]  = '{1, 32'h200, 1, 0, 0,        0, 0, 32'hC,   0,   0,                         0,                 0};
        vt[8]  = '{0, 0, 1, 0, 0,              0, 1, 32'h200, 0,   0,                         0,                 0};
        vt[9]  = '{0, 0, 1, 1, memWord(32'h200), 0, 0, 32'h204, BYP, sel(BYP, memWord(32'h200)), sel(BYP, 32'h204), 0};
        vt[10] = '{0, 0, 0, 0, 0,              0, 1, 32'h204, NBY, sel(NBY, memWord(32'h200)), sel(NBY, 32'h204), int'(NBY)};

        // Reset held for three edges; outputs checked while still in reset.
        Reset = 0; RedirectValid = 0; RedirectPC = 0; DecodeStall = 0;
        IReqReady = 0; IRespValid = 0; IRespData = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset IReqValid", 32'(IReqValid), 0);
        check("reset InstrValidD", 32'(InstrValidD), 0);
        check("reset InstrD", InstrD, 0);
        check("reset PCPlus4D", PCPlus4D, 0);
        check("reset QueueCount", 32'(QueueCount), 0);
        check("reset IReqAddr", IReqAddr, 32'h0);
        @(posedge CLK);
        #1;
        Reset = 1;

        foreach (vt[i]) begin
            RedirectValid = vt[i].redir; RedirectPC = vt[i].rpc; IReqReady = vt[i].ready;
            IRespValid = vt[i].resp; IRespData = vt[i].data; DecodeStall = vt[i].stall;
            @(negedge CLK);
            check($sformatf("v%0d IReqValid", i), 32'(IReqValid), 32'(vt[i].eReq));
            check($sformatf("v%0d IReqAddr", i), IReqAddr, vt[i].eAddr);
            check($sformatf("v%0d InstrValidD", i), 32'(InstrValidD), 32'(vt[i].eValid));
            check($sformatf("v%0d InstrD", i), InstrD, vt[i].eInstr);
            check($sformatf("v%0d PCPlus4D", i), PCPlus4D, vt[i].ePc4);
            check($sformatf("v%0d QueueCount", i), 32'(QueueCount), 32'(vt[i].eCount));
            $display("vec %0d: req=%b addr=%h valid=%b instr=%h pc4=%h count=%0d",
                     i, IReqValid, IReqAddr, InstrValidD, InstrD, PCPlus4D, QueueCount);
            @(posedge CLK);
            #1;
        end
        RedirectValid = 0; IRespValid = 0;

        // Decode stalled: queue fills to DEPTH, fetch stops, head holds; release pops 4 in a row.
        DecodeStall = 1; readyEn = 1; memLatency = 1; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            stepNeg();
            if (QueueCount == 3'(DEPTH)) got = 1;
            else memEdge();
        end
        check("fill reached DEPTH", 32'(got), 1);
        headI = InstrD; headP = PCPlus4D;
        check("fill head instr", headI, memWord(headP - 32'd4));
        check("fill IReqValid", 32'(IReqValid), 0);
        memEdge();
        for (int c = 0; c < 3; c++) begin
            stepNeg();
            check("full IReqValid", 32'(IReqValid), 0);
            check("full QueueCount", 32'(QueueCount), DEPTH);
            check("full head InstrD", InstrD, headI);
            check("full head PCPlus4D", PCPlus4D, headP);
            memEdge();
        end
        DecodeStall = 0;
        for (int k = 0; k < 4; k++) begin
            stepNeg();
            check($sformatf("drain%0d valid", k), 32'(InstrValidD), 1);
            check($sformatf("drain%0d pc4", k), PCPlus4D, headP + 32'(4 * k));
            check($sformatf("drain%0d instr", k), InstrD, memWord(headP + 32'(4 * k) - 32'd4));
            if (k == 0) check("drain0 count", 32'(QueueCount), 4);
            if (k == 1) begin
                check("drain1 count", 32'(QueueCount), 3);
                check("drain1 fetch resumes", 32'(IReqValid), 1);
            end
            memEdge();
        end
        $display("stall/fill sequence done, head pc4=%h", headP);

        // Slow memory, redirect to 0x100 while a request is outstanding.
        memLatency = 5; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            stepNeg();
            got = IReqValid && IReqReady;
            memEdge();
        end
        check("slow fire seen", 32'(got), 1);
        stepNeg(); memEdge();
        RedirectValid = 1; RedirectPC = 32'h100;
        stepNeg();
        check("redir-wait IReqValid", 32'(IReqValid), 0);
        memEdge();
        RedirectValid = 0;
        stepNeg();
        check("redir-wait InstrValidD next", 32'(InstrValidD), 0);
        check("redir-wait drop no req", 32'(IReqValid), 0);
        memEdge();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            stepNeg();
            if (IReqValid) begin
                got = 1;
                check("redir-wait first addr", IReqAddr, 32'h100);
            end else if (InstrValidD) begin
                check("redir-wait stale valid", 32'(InstrValidD), 0);
            end
            memEdge();
        end
        check("redir-wait req seen", 32'(got), 1);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            stepNeg();
            if (InstrValidD) begin
                got = 1;
                check("redir-wait first pc4", PCPlus4D, 32'h104);
                check("redir-wait first instr", InstrD, memWord(32'h100));
            end
            memEdge();
        end
        check("redir-wait instr seen", 32'(got), 1);
        $display("slow-memory redirect sequence done");

        // Redirect coinciding with a response and a pop on a 2-entry queue.
        memLatency = 1; DecodeStall = 1; RedirectValid = 1; RedirectPC = 32'h280;
        stepNeg(); memEdge();
        RedirectValid = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            stepNeg();
            if (QueueCount == 3'd2 && IRespValid) got = 1;
            else memEdge();
        end
        check("coinc setup", 32'(got), 1);
        DecodeStall = 0; RedirectValid = 1; RedirectPC = 32'h300;
        #1;
        memEdge();
        RedirectValid = 0;
        stepNeg();
        check("coinc QueueCount", 32'(QueueCount), 0);
        check("coinc InstrValidD", 32'(InstrValidD), 0);
        check("coinc issue state", 32'(IReqValid), 1);
        check("coinc IReqAddr", IReqAddr, 32'h300);
        memEdge();
        $display("coincident redirect sequence done");

        // PC wrap at the top of the address space.
        RedirectValid = 1; RedirectPC = 32'hFFFF_FFFC;
        stepNeg(); memEdge();
        RedirectValid = 0; nf = 0; seen = 0;
        fires[0] = 32'h1; fires[1] = 32'h1;
        for (int c = 0; c < 30 && !(seen && nf == 2); c++) begin
            stepNeg();
            if (IReqValid && IReqReady && nf < 2) begin
                fires[nf] = IReqAddr;
                nf++;
            end
            if (InstrValidD && !seen) begin
                seen = 1;
                check("wrap pc4", PCPlus4D, 32'h0);
                check("wrap instr", InstrD, memWord(32'hFFFF_FFFC));
            end
            memEdge();
        end
        check("wrap first addr", fires[0], 32'hFFFF_FFFC);
        check("wrap next addr", fires[1], 32'h0);
        $display("wrap sequence done");

        // Random traffic against a queue-level reference model.
        Reset = 0; RedirectValid = 0; IRespValid = 0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1; memPend = 0; memCnt = 0;
        mq.delete(); mOut = 0; mDoom = 0; mPc = 32'h0; mReqPc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            bit          eReq, eValid, bypNow, acc, r, haveResp, wasDoom;
            logic [31:0] eI, eP;
            RedirectValid = ($urandom_range(0, 19) == 0);
            RedirectPC    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            DecodeStall   = ($urandom_range(0, 9) < 3);
            readyEn       = ($urandom_range(0, 3) != 0);
            memLatency    = $urandom_range(1, 4);
            memDrive();
            if (!memPend && $urandom_range(0, 19) == 0) begin
                IRespValid = 1;
                IRespData  = $urandom;
            end
            @(negedge CLK);
            r      = IRespValid;
            bypNow = BYP && mq.size() == 0 && mOut && !mDoom && r && !RedirectValid;
            eReq   = !mOut && mq.size() < DEPTH && !RedirectValid;
            eValid = (mq.size() > 0) || bypNow;
            eI = 32'h0; eP = 32'h0;
            if (mq.size() > 0) begin
                eI = mq[0].ins; eP = mq[0].pc4;
            end else if (bypNow) begin
                eI = IRespData; eP = mReqPc + 32'd4;
            end
            check("rnd IReqValid", 32'(IReqValid), 32'(eReq));
            check("rnd IReqAddr", IReqAddr, mPc);
            check("rnd InstrValidD", 32'(InstrValidD), 32'(eValid));
            check("rnd InstrD", InstrD, eI);
            check("rnd PCPlus4D", PCPlus4D, eP);
            check("rnd QueueCount", 32'(QueueCount), mq.size());
            acc = eReq && IReqReady;
            if (RedirectValid) begin
                mq.delete();
                if (mOut) begin
                    if (r) begin mOut = 0; mDoom = 0; end
                    else mDoom = 1;
                end
                mPc = RedirectPC;
            end else begin
                haveResp = mOut && r && !mDoom;
                wasDoom  = mOut && r && mDoom;
                if (mq.size() > 0 && !DecodeStall) void'(mq.pop_front());
                if (haveResp && !(bypNow && !DecodeStall)) mq.push_back('{mReqPc + 32'd4, IRespData});
                if (haveResp || wasDoom) begin mOut = 0; mDoom = 0; end
                if (acc) begin
                    mOut = 1; mReqPc = mPc; mPc = mPc + 32'd4;
                end
            end
            memEdge();
        end
        $display("random phase done, final model occupancy %0d", mq.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised fetch stage for the pipelined MIPS core. It replaces the single PC register and IF/ID register with a PC generator, a variable-latency instruction-memory handshake, and a DEPTH-entry instruction queue. The queue decouples fetch from decode, so instruction-cache misses and decode stalls no longer lock each other. Branch and jump redirects from decode flush the queue and discard any in-flight response.

## Interface
- WIDTH, 32, address and instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch address after reset

- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- RedirectValid  in  1  taken branch or jump from decode (PCSrcD|JumpD)
- RedirectPC  in  WIDTH  redirect target
- IReqValid  out  1  fetch request valid
- IReqAddr  out  WIDTH  fetch address
- IReqReady  in  1  memory accepts the request
- IRespValid  in  1  instruction returned
- IRespData  in  WIDTH  returned instruction word
- InstrValidD  out  1  queue head valid for decode
- InstrD  out  WIDTH  queue head instruction; 0 (NOP) when not valid
- PCPlus4D  out  WIDTH  head PC+4; 0 when not valid
- DecodeStall  in  1  decode holds the head (stallD)
- QueueCount  out  $clog2(DEPTH+1)  occupied entries

## Operation
- FSM states:
  - ISSUE: a request may be presented.
  - WAIT: one request is outstanding.
  - DROP: one outstanding request must be discarded.
- At most one request is outstanding at any time.
- IReqValid = (state==ISSUE) & (QueueCount < DEPTH) & ~RedirectValid. IReqAddr is the fetch PC.
- Handshake: IReqValid & IReqReady moves the FSM from ISSUE to WAIT, and the fetch PC advances by 4, wrapping mod 2^WIDTH.
- In WAIT, IRespValid pushes {PC+4, IRespData} into the queue and returns the FSM to ISSUE.
- The credit rule guarantees a free slot for every response, so a push never overflows.
- IRespValid in ISSUE is spurious and ignored.
- Pop happens when InstrValidD & ~DecodeStall. InstrD and PCPlus4D always show the head entry.
- Simultaneous push and pop: count is unchanged, and both pointers advance and wrap modulo DEPTH.
- Redirect (RedirectValid=1) has priority over everything else in the same cycle:
  - The queue is cleared (count=0), and any same-cycle push or pop is discarded.
  - Fetch PC loads RedirectPC.
  - WAIT goes to DROP; in that cycle a same-cycle IRespValid is discarded and the FSM goes to ISSUE instead of DROP.
  - ISSUE stays ISSUE.
  - DROP with IRespValid goes to ISSUE; DROP without it stays DROP.
- In DROP, the next IRespValid is discarded and the FSM returns to ISSUE.
- Reset (Reset=0):
  - fetch PC = RESET_PC, queue empty, FSM = ISSUE.
  - Outputs: IReqValid=0, InstrValidD=0, InstrD=0, PCPlus4D=0, QueueCount=0.
  - Reset mid-request abandons the transaction. Memory must also be reset.

## Timing
- Request accepted at edge t; the response is sampled no earlier than cycle t+1.
- Without bypass, a response sampled in cycle r is visible at the head in cycle r+1.
- Best-case steady state is one instruction every 2 cycles per outstanding request slot.
- Redirect in cycle t: InstrValidD=0 in cycle t+1. IReqAddr=RedirectPC in cycle t+1 if the FSM is in ISSUE.
- The pop is visible through QueueCount in the next cycle.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty, FSM is WAIT, IRespValid=1 and RedirectValid=0, the response drives InstrValidD, InstrD and PCPlus4D combinationally in the same cycle.
  - If DecodeStall=0, the response is consumed without being written to the queue.
  - If DecodeStall=1, it is pushed.
- Undefined: no combinational path from IResp* to the decode outputs; minimum response-to-decode latency is 1 cycle.

## Test plan
- Reset held 3 cycles, memory with 1-cycle latency → first IReqAddr=0x0, then 0x4, 0x8. InstrD equals memory words in order, with PCPlus4D=0x4, 0x8, 0xC.
- DecodeStall held high, DEPTH=4 → QueueCount reaches 4, IReqValid stays 0, head unchanged. Release → 4 pops in consecutive cycles and fetch resumes.
- Memory latency 5 cycles; redirect to 0x100 while in WAIT → late response discarded, next IReqAddr=0x100, first decoded PCPlus4D=0x104.
- Redirect coincident with IRespValid and pop on a 2-entry queue → QueueCount=0 next cycle, nothing pushed, FSM in ISSUE.
- Fetch PC at 0xFFFF_FFFC → next IReqAddr=0x0, and that entry's PCPlus4D=0x0.
- With FETCH_BYPASS_EN, empty queue, DecodeStall=0 → InstrValidD=1 in the same cycle as IRespValid and QueueCount stays 0. Without the macro → InstrValidD=1 one cycle later.
